matrix_buffer: RTL and testbench

MATRIX_BUFFER -- requirements
Module: matrix_buffer

---
 rtl/matrix_buffer_if.sv | 29 ++
 rtl/matrix_buffer.sv | 138 +++++++++++++
 tb/tb_matrix_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/matrix_buffer_if.sv
// Handshake/data bundle for matrix_buffer: push/pop side inputs and status outputs.
interface matrix_buffer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N      = 4
);
    localparam int unsigned CNT_W = $clog2(N * N + 1);

    logic              clr;
    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic              transpose;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              err;

    modport slave (
        input  clr, push, data_in, pop, transpose,
        output data_out, data_valid, full, empty, count, err
    );

    modport master (
        output clr, push, data_in, pop, transpose,
        input  data_out, data_valid, full, empty, count, err
    );
endinterface

// File: rtl/matrix_buffer.sv
// N x N matrix buffer: fill row-major, drain row- or column-major with 1-cycle read latency.
// Optional MATRIX_BUFFER_REPLAY_EN: end of drain returns to READY for unlimited re-reads.
module matrix_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N      = 4
) (
    input logic           clk,
    input logic           rst,
    matrix_buffer_if.slave bus
);
    localparam int unsigned DEPTH = N * N;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned RCW   = $clog2(N);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StFill, StReady, StDrain} state_e;

    state_e            state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [RCW-1:0]    row_q, col_q;
    logic              mode_q;
    logic [CNT_W-1:0]  count_q;
    logic              valid_q, full_q, empty_q, err_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic           do_push, do_pop, mode_eff, last_rd, illegal;
    logic [AW-1:0]  raddr;
    logic [RCW-1:0] row_d, col_d;

    always_comb begin
        do_push  = bus.push && (state_q == StFill) && !bus.clr;
        do_pop   = bus.pop && (state_q != StFill) && !bus.clr;
        illegal  = (bus.push && (state_q != StFill)) || (bus.pop && (state_q == StFill));
        // First pop of a pass reads the live transpose; later pops use the latched mode.
        mode_eff = (state_q == StReady) ? bus.transpose : mode_q;
        raddr    = mode_eff ? (AW'(col_q) * AW'(N) + AW'(row_q))
                            : (AW'(row_q) * AW'(N) + AW'(col_q));
        last_rd  = (row_q == RCW'(N - 1)) && (col_q == RCW'(N - 1));
        row_d    = row_q;
        col_d    = col_q + 1'b1;
        if (col_q == RCW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end
        if (last_rd) begin
            row_d = '0;
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (do_pop) begin
            dout_q <= mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state_q  <= StFill;
            wr_ptr_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            mode_q   <= 1'b0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            valid_q <= do_pop;
            if (illegal) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StFill: begin
                    if (do_push) begin
                        count_q <= count_q + 1'b1;
                        empty_q <= 1'b0;
                        if (wr_ptr_q == AW'(DEPTH - 1)) begin
                            wr_ptr_q <= '0;
                            state_q  <= StReady;
                            full_q   <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                StReady: begin
                    if (do_pop) begin
                        mode_q  <= bus.transpose;
                        state_q <= StDrain;
                        full_q  <= 1'b0;
                        count_q <= count_q - 1'b1;
                        row_q   <= row_d;
                        col_q   <= col_d;
                    end
                end
                StDrain: begin
                    if (do_pop) begin
                        row_q <= row_d;
                        col_q <= col_d;
                        if (last_rd) begin
`ifdef MATRIX_BUFFER_REPLAY_EN
                            state_q <= StReady;
                            count_q <= CNT_W'(DEPTH);
                            full_q  <= 1'b1;
                            empty_q <= 1'b0;
`else
                            state_q <= StFill;
                            count_q <= '0;
                            empty_q <= 1'b1;
`endif
                        end else begin
                            count_q <= count_q - 1'b1;
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.count      = count_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_matrix_buffer.sv
// Table-driven bench for matrix_buffer (N=4, DATA_W=16); honours MATRIX_BUFFER_REPLAY_EN.
module tb_matrix_buffer;
    localparam int unsigned DW = 16;
    localparam int unsigned NN = 4;

    typedef struct {
        bit        push;
        bit [15:0] din;
        bit        pop;
        bit        tr;
        bit        clr;
        bit        rst;
        bit        ev;
        bit [15:0] ed;
        bit        ef;
        bit        ee;
        bit [4:0]  ec;
        bit        er;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_buffer_if #(.DATA_W(DW), .N(NN)) bus ();

    matrix_buffer #(.DATA_W(DW), .N(NN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t      tab [400];
    int        nv = 0;
    int        n_cmp = 0;
    int        n_bad = 0;
    // Expected-state tracking while building the table.
    bit [4:0]  ec = 0;
    bit        ef = 0, ee = 1, er = 0;
    bit [15:0] ld = 0;

    function automatic void add(bit p, bit [15:0] d, bit po, bit tr, bit c, bit r, bit ev);
        tab[nv] = '{p, d, po, tr, c, r, ev, ld, ef, ee, ec, er};
        nv++;
    endfunction

    function automatic void fill_n(int cnt);
        for (int i = 0; i < cnt; i++) begin
            ec = ec + 1;
            ee = 0;
            ef = (ec == 16);
            add(1, 16'(i), 0, 0, 0, 0, 0);
        end
    endfunction

    // Data written equals its row-major index, so expected value is the read address.
    function automatic void drain_n(bit mode, bit toggle, int cnt);
        for (int k = 0; k < cnt; k++) begin
            bit tr;
            ld = mode ? 16'((k % 4) * 4 + k / 4) : 16'(k);
            tr = toggle ? (mode ^ bit'(k % 2)) : mode;
            if (k == 15) begin
`ifdef MATRIX_BUFFER_REPLAY_EN
                ec = 16; ef = 1; ee = 0;
`else
                ec = 0; ef = 0; ee = 1;
`endif
            end else begin
                ec = ec - 1; ef = 0; ee = 0;
            end
            add(0, 0, 1, tr, 0, 0, 1);
        end
    endfunction

    function automatic void idle();
        add(0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void clr_all();
        ec = 0; ef = 0; ee = 1; er = 0;
        add(1, 16'hdead, 1, 0, 1, 0, 0);
    endfunction

    function automatic void bad_pop();
        er = 1;
        add(0, 0, 1, 0, 0, 0, 0);
    endfunction

    function automatic void bad_push();
        er = 1;
        add(1, 16'd99, 0, 0, 0, 0, 0);
    endfunction

    function automatic void rst_all(bit others);
        ec = 0; ef = 0; ee = 1; er = 0; ld = 0;
        add(others, 16'd55, others, others, others, 1, 0);
    endfunction

    task automatic check(int idx, string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %0h want %0h", idx, name, act, exp);
        end
    endtask

    initial begin
        rst_all(0);
        rst_all(0);
        fill_n(16);
        idle();
        drain_n(0, 0, 16);
        idle();
`ifdef MATRIX_BUFFER_REPLAY_EN
        drain_n(1, 1, 16);
        idle();
        bad_push();
        drain_n(0, 0, 16);
        clr_all();
`else
        bad_pop();
        clr_all();
        fill_n(16);
        drain_n(1, 1, 16);
        fill_n(16);
        bad_push();
        drain_n(0, 0, 16);
        clr_all();
`endif
        fill_n(3);
        bad_pop();
        idle();
        clr_all();
        fill_n(16);
        drain_n(0, 0, 8);
        rst_all(1);
        fill_n(1);
        idle();

        bus.clr = 0; bus.push = 0; bus.pop = 0; bus.transpose = 0; bus.data_in = '0;
        for (int i = 0; i < nv; i++) begin
            rst           = tab[i].rst;
            bus.clr       = tab[i].clr;
            bus.push      = tab[i].push;
            bus.data_in   = tab[i].din;
            bus.pop       = tab[i].pop;
            bus.transpose = tab[i].tr;
            @(posedge clk);
            #1;
            check(i, "data_valid", int'(bus.data_valid), int'(tab[i].ev));
            check(i, "data_out", int'(bus.data_out), int'(tab[i].ed));
            check(i, "full", int'(bus.full), int'(tab[i].ef));
            check(i, "empty", int'(bus.empty), int'(tab[i].ee));
            check(i, "count", int'(bus.count), int'(tab[i].ec));
            check(i, "err", int'(bus.err), int'(tab[i].er));
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
